// File: rtl/pluto_sweep_pkg.sv
// Shared types and default widths for the Pluto TX sweep sequencer.
// Holds the FSM state encoding and the per-state control output decode.
package pluto_sweep_pkg;

  localparam int unsigned LEN_W_DEF  = 32;
  localparam int unsigned GAP_W_DEF  = 16;
  localparam int unsigned REP_W_DEF  = 8;
  localparam int unsigned IQ_LAT_DEF = 4;
  localparam int unsigned INC_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic sweep_reset;
    logic sweep_enable;
    logic busy;
    logic done;
  } ctrl_t;

  // Control outputs that accompany a given state; registered alongside the state.
  function automatic ctrl_t ctrl_for(input state_e s);
    ctrl_t c;
    c.sweep_reset  = 1'b1;
    c.sweep_enable = 1'b0;
    c.busy         = 1'b1;
    c.done         = 1'b0;
    case (s)
      ST_IDLE: c.busy = 1'b0;
      ST_RUN: begin
        c.sweep_reset  = 1'b0;
        c.sweep_enable = 1'b1;
      end
      ST_DONE: c.done = 1'b1;
      default: c.busy = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sweep_sequencer_bit_delay.sv
// 1-bit shift register with synchronous active-high reset.
// DEPTH=0 degenerates to a combinational pass-through.
module bit_delay #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_shift
      logic [DEPTH-1:0] r_sh;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sh <= '0;
        end else begin
          r_sh[0] <= i_d;
          for (int i = 1; i < int'(DEPTH); i++) begin
            r_sh[i] <= r_sh[i-1];
          end
        end
      end

      assign o_q = r_sh[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sweep_sequencer.sv
// Sequences repeated linear chirps: drives the sweep NCO reset/enable/increment
// and steers the I/Q mux to the generator while a sweep is running.
module sweep_sequencer
  import pluto_sweep_pkg::*;
#(
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned GAP_W  = GAP_W_DEF,
  parameter int unsigned REP_W  = REP_W_DEF,
  parameter int unsigned IQ_LAT = IQ_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    valid,
  input  logic [INC_W-1:0]        cfg_increment,
  input  logic [LEN_W-1:0]        cfg_sweep_len,
  input  logic [GAP_W-1:0]        cfg_gap_len,
  input  logic [REP_W-1:0]        cfg_repeats,
  output logic                    sweep_reset,
  output logic                    sweep_enable,
  output logic [INC_W-1:0]        sweep_increment,
  output logic                    iq_sel,
  output logic                    busy,
  output logic                    done,
  output logic [REP_W-1:0]        sweep_count
);

  state_e           r_state;
  ctrl_t            r_ctrl;
  logic [INC_W-1:0] r_inc;
  logic [LEN_W-1:0] r_len;
  logic [GAP_W-1:0] r_gap;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_count;
  logic [LEN_W-1:0] r_cnt;

  logic             w_len_last;
  logic             w_gap_last;
  logic [REP_W-1:0] w_count_inc;
  logic             w_reps_hit;

  assign w_len_last  = (r_cnt == (r_len - LEN_W'(1)));
  assign w_gap_last  = (r_cnt == (LEN_W'(r_gap) - LEN_W'(1)));
  assign w_count_inc = r_count + REP_W'(1);
  assign w_reps_hit  = (r_reps != '0) && (w_count_inc == r_reps);

  // Single-process FSM; control outputs are registered with the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ctrl  <= ctrl_for(ST_IDLE);
      r_inc   <= '0;
      r_len   <= '0;
      r_gap   <= '0;
      r_reps  <= '0;
      r_count <= '0;
      r_cnt   <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      // Abort wins over completion and start; sweep_count is left untouched.
      r_state <= ST_IDLE;
      r_ctrl  <= ctrl_for(ST_IDLE);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_inc   <= cfg_increment;
            r_len   <= cfg_sweep_len;
            r_gap   <= cfg_gap_len;
            r_reps  <= cfg_repeats;
            r_count <= '0;
            r_cnt   <= '0;
            // Generator is already held in reset here, so CLEAR is not needed.
            if (cfg_sweep_len == '0) begin
              r_state <= ST_DONE;
              r_ctrl  <= ctrl_for(ST_DONE);
            end else begin
              r_state <= ST_RUN;
              r_ctrl  <= ctrl_for(ST_RUN);
            end
          end
        end

        ST_CLEAR: begin
          r_state <= ST_RUN;
          r_ctrl  <= ctrl_for(ST_RUN);
        end

        ST_RUN: begin
          if (valid) begin
            if (w_len_last) begin
              r_cnt   <= '0;
              r_count <= w_count_inc;
              if (w_reps_hit) begin
                r_state <= ST_DONE;
                r_ctrl  <= ctrl_for(ST_DONE);
              end else if (r_gap == '0) begin
                r_state <= ST_CLEAR;
                r_ctrl  <= ctrl_for(ST_CLEAR);
              end else begin
                r_state <= ST_GAP;
                r_ctrl  <= ctrl_for(ST_GAP);
              end
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
        end

        ST_GAP: begin
          if (valid) begin
            if (w_gap_last) begin
              r_cnt   <= '0;
              r_state <= ST_RUN;
              r_ctrl  <= ctrl_for(ST_RUN);
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ctrl  <= ctrl_for(ST_IDLE);
        end
      endcase
    end
  end

  // The registered enable doubles as the run flag feeding the I/Q lag line.
  bit_delay #(
    .DEPTH (IQ_LAT)
  ) u_iq_delay (
    .clk   (clk),
    .reset (reset),
    .i_d   (r_ctrl.sweep_enable),
    .o_q   (iq_sel)
  );

  assign sweep_reset     = r_ctrl.sweep_reset;
  assign sweep_enable    = r_ctrl.sweep_enable;
  assign busy            = r_ctrl.busy;
  assign done            = r_ctrl.done;
  assign sweep_increment = r_inc;
  assign sweep_count     = r_count;

endmodule
